// File: rtl/song_pkg.sv
// song_pkg: shared definitions for the song sequencer.
//   - FSM state encoding
//   - ROM entry field positions (tone in the high nibble, beat in the low nibble)
//   - Special codes: END_MARKER beat code, REST_TONE tone code
package song_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    localparam int TONE_MSB = 7;
    localparam int TONE_LSB = 4;
    localparam int BEAT_MSB = 3;
    localparam int BEAT_LSB = 0;

    localparam int DUR_W = 28;

    localparam logic [3:0] END_MARKER = 4'h0;
    localparam logic [3:0] REST_TONE  = 4'h0;

    function automatic logic is_end_marker(input logic [3:0] beat_code);
        return beat_code == END_MARKER;
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// song_sequencer_if: bundles the song ROM read port and the beat decoder link.
//   rom_addr            sequencer -> ROM, read address
//   rom_data            ROM -> sequencer, entry read one cycle after rom_addr
//   beat                sequencer -> beat decoder, beat code of the current note
//   beat_cnt_parameter  beat decoder -> sequencer, note duration in cycles (0 = invalid)
// master: the sequencer. slave: the ROM / beat decoder side.
interface song_sequencer_if #(
    parameter int ADDR_W = 8
) ();
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [3:0]        beat;
    logic [27:0]       beat_cnt_parameter;

    modport master (
        output rom_addr,
        output beat,
        input  rom_data,
        input  beat_cnt_parameter
    );

    modport slave (
        input  rom_addr,
        input  beat,
        output rom_data,
        output beat_cnt_parameter
    );
endinterface

// File: rtl/song_sequencer_note_timer.sv
// note_timer: duration counter for one note.
//   clk, rst_n      clock, asynchronous active-low reset
//   i_clr           clear the count (takes priority over i_en)
//   i_en            count one cycle
//   i_dur           note length D in cycles (0 = invalid)
//   o_sound_done    last audible cycle of a note that ends with a gap
//   o_note_done     last cycle of the whole note (count == D-1)
//   o_dur_zero      D is zero, i.e. the beat code decoded to nothing
module note_timer
    import song_pkg::*;
#(
    parameter logic [DUR_W-1:0] GAP_CYCLES = 28'd500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [DUR_W-1:0] i_dur,
    output logic             o_sound_done,
    output logic             o_note_done,
    output logic             o_dur_zero
);

    logic [DUR_W-1:0] r_cnt;
    logic             w_has_gap;
    logic [DUR_W-1:0] w_sound_end;
    logic [DUR_W-1:0] w_note_end;

    // A zero-length gap would put the sound end on the same cycle as the
    // note end, after which the gap state could never see note_done.
    assign w_has_gap   = (i_dur > GAP_CYCLES) && (GAP_CYCLES != '0);
    // Only meaningful when w_has_gap; otherwise the subtraction may wrap.
    assign w_sound_end = i_dur - GAP_CYCLES - DUR_W'(1);
    assign w_note_end  = i_dur - DUR_W'(1);

    assign o_dur_zero   = (i_dur == '0);
    assign o_sound_done = w_has_gap && (r_cnt == w_sound_end);
    assign o_note_done  = !o_dur_zero && (r_cnt == w_note_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + DUR_W'(1);
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: walks a song ROM one note entry at a time.
//   clk, rst_n   clock, asynchronous active-low reset
//   start        pulse: (re)start playback from address 0
//   stop         pulse: abort playback (wins over start)
//   loop_en      wrap to address 0 at the end-of-song marker instead of finishing
//   bus          ROM read port + beat decoder link (master side)
//   tone         registered tone code of the current note
//   tone_on      high while the current note sounds (not a rest, not in the gap)
//   playing      high in every state except IDLE
//   song_done    one-cycle pulse when a non-looping song ends
// Each note costs FETCH + LOAD + D cycles; the last GAP_CYCLES of D are silent
// when D is long enough to hold the gap.
module song_sequencer
    import song_pkg::*;
#(
    parameter int               ADDR_W     = 8,
    parameter logic [DUR_W-1:0] GAP_CYCLES = 28'd500000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   loop_en,
    song_sequencer_if.master       bus,
    output logic [3:0]             tone,
    output logic                   tone_on,
    output logic                   playing,
    output logic                   song_done
);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
    logic [3:0]        r_tone,  w_tone_nxt;
    logic [3:0]        r_beat,  w_beat_nxt;
    logic              r_song_done, w_done_nxt;

    logic              w_clr, w_en, w_end;
    logic              w_sound_done, w_note_done, w_dur_zero;
    logic [3:0]        w_rom_beat;

    assign w_rom_beat = bus.rom_data[BEAT_MSB:BEAT_LSB];

    note_timer #(
        .GAP_CYCLES (GAP_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (w_clr),
        .i_en         (w_en),
        .i_dur        (bus.beat_cnt_parameter),
        .o_sound_done (w_sound_done),
        .o_note_done  (w_note_done),
        .o_dur_zero   (w_dur_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_tone      <= '0;
            r_beat      <= '0;
            r_song_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_tone      <= w_tone_nxt;
            r_beat      <= w_beat_nxt;
            r_song_done <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_tone_nxt  = r_tone;
        w_beat_nxt  = r_beat;
        w_done_nxt  = 1'b0;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        w_end       = 1'b0;

        if (stop) begin
            // stop in IDLE is a no-op; it also swallows a coincident start.
            if (r_state != S_IDLE) begin
                w_state_nxt = S_IDLE;
                w_tone_nxt  = '0;
                w_beat_nxt  = '0;
                w_clr       = 1'b1;
            end
        end else if (start) begin
            w_state_nxt = S_FETCH;
            w_addr_nxt  = '0;
            w_clr       = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: ;
                S_FETCH: w_state_nxt = S_LOAD;
                S_LOAD: begin
                    w_tone_nxt = bus.rom_data[TONE_MSB:TONE_LSB];
                    w_beat_nxt = w_rom_beat;
                    w_clr      = 1'b1;
                    if (is_end_marker(w_rom_beat)) w_end = 1'b1;
                    else                           w_state_nxt = S_PLAY;
                end
                S_PLAY: begin
                    w_en = 1'b1;
                    // The decoder answer for the new beat is first visible
                    // here, so an undecodable beat ends the song from PLAY.
                    if (w_dur_zero) begin
                        w_end = 1'b1;
                    end else if (w_sound_done) begin
                        w_state_nxt = S_GAP;
                    end else if (w_note_done) begin
                        w_addr_nxt  = r_addr + ADDR_W'(1);
                        w_state_nxt = S_FETCH;
                    end
                end
                S_GAP: begin
                    w_en = 1'b1;
                    if (w_note_done) begin
                        w_addr_nxt  = r_addr + ADDR_W'(1);
                        w_state_nxt = S_FETCH;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase

            if (w_end) begin
                if (loop_en) begin
                    w_addr_nxt  = '0;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    w_tone_nxt  = '0;
                    w_beat_nxt  = '0;
                end
            end
        end
    end

    assign bus.rom_addr = r_addr;
    assign bus.beat     = r_beat;
    assign tone         = r_tone;
    assign song_done    = r_song_done;
    assign playing      = (r_state != S_IDLE);
    // Rests and undecodable beats never sound; the gap is silent by state.
    assign tone_on      = (r_state == S_PLAY) && (r_tone != REST_TONE) && !w_dur_zero;

endmodule
